dram_image_sequencer: RTL

// - Host-side stage wrapping the downsampling CPU's external DRAM port: streams an input image into DRAM,

---
 rtl/dram_image_sequencer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/dram_image_sequencer.sv
// Host sequencer for the downsampling CPU DRAM port: load, run, read back.
// Optional checksums are built only when SEQ_CHECKSUM_EN is defined.
module dram_image_sequencer #(
  parameter int ADDR_W    = 16,
  parameter int IMG_BYTES = 65536,
  parameter int OUT_BASE  = 0,
  parameter int OUT_BYTES = 16384
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [7:0]        m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [7:0]        data_in,
  output logic [ADDR_W-1:0] add_in,
  output logic              data_write,
  output logic              data_read,
  output logic              selection,
  output logic              enable,
  input  logic              finish,
  input  logic [7:0]        data_out,
  output logic              busy,
  output logic              done,
  output logic [15:0]       load_sum,
  output logic [15:0]       out_sum
);

  typedef enum logic [2:0] {
    IDLE, LOAD, LOAD_END, RUN, RD_REQ, RD_WAIT, SEND, DONE
  } state_t;

  localparam logic [ADDR_W:0] IMG_LAST =
    (ADDR_W+1)'(IMG_BYTES - 1);
  localparam logic [ADDR_W:0] OUT_LAST =
    (ADDR_W+1)'(OUT_BYTES > 0 ? OUT_BYTES - 1 : 0);
  localparam logic [ADDR_W-1:0] RD_BASE =
    (ADDR_W)'(OUT_BASE);

  state_t            state;
  // One extra bit so a full 2^ADDR_W image does not wrap early
  logic [ADDR_W:0]   wr_addr;
  logic [ADDR_W:0]   rd_cnt;
  logic [ADDR_W-1:0] rd_addr;

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      s_ready    <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      data_in    <= '0;
      add_in     <= '0;
      data_write <= 1'b0;
      data_read  <= 1'b0;
      selection  <= 1'b0;
      enable     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wr_addr    <= '0;
      rd_cnt     <= '0;
      rd_addr    <= '0;
`ifdef SEQ_CHECKSUM_EN
      load_sum   <= '0;
      out_sum    <= '0;
`endif
    end else begin
      data_write <= 1'b0;
      data_read  <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= LOAD;
            s_ready <= 1'b1;
            busy    <= 1'b1;
            done    <= 1'b0;
            wr_addr <= '0;
            rd_cnt  <= '0;
            rd_addr <= RD_BASE;
`ifdef SEQ_CHECKSUM_EN
            load_sum <= '0;
            out_sum  <= '0;
`endif
          end
        end
        LOAD: begin
          if (s_valid && s_ready) begin
            data_in    <= s_data;
            add_in     <= wr_addr[ADDR_W-1:0];
            data_write <= 1'b1;
            wr_addr    <= wr_addr + 1'b1;
`ifdef SEQ_CHECKSUM_EN
            load_sum   <= load_sum + {8'h00, s_data};
`endif
            if (wr_addr == IMG_LAST) begin
              s_ready <= 1'b0;
              state   <= LOAD_END;
            end
          end
        end
        LOAD_END: begin
          selection <= 1'b1;
          enable    <= 1'b1;
          state     <= RUN;
        end
        RUN: begin
          if (finish) begin
            enable    <= 1'b0;
            selection <= 1'b0;
            rd_addr   <= RD_BASE;
            rd_cnt    <= '0;
            if (OUT_BYTES == 0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state     <= RD_REQ;
              add_in    <= RD_BASE;
              data_read <= 1'b1;
            end
          end
        end
        RD_REQ: state <= RD_WAIT;
        RD_WAIT: begin
          m_data  <= data_out;
          m_valid <= 1'b1;
          state   <= SEND;
        end
        SEND: begin
          if (m_ready) begin
            m_valid <= 1'b0;
`ifdef SEQ_CHECKSUM_EN
            out_sum <= out_sum + {8'h00, m_data};
`endif
            if (rd_cnt == OUT_LAST) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              rd_cnt    <= rd_cnt + 1'b1;
              rd_addr   <= rd_addr + 1'b1;
              add_in    <= rd_addr + 1'b1;
              data_read <= 1'b1;
              state     <= RD_REQ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SEQ_CHECKSUM_EN
  assign load_sum = '0;
  assign out_sum  = '0;
`endif

endmodule
